// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I core: data width, reset vector, bubble word and
// fetch state encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t F_IDLE   = 2'd0;
    localparam fetch_state_t F_STREAM = 2'd1;
    localparam fetch_state_t F_HELD   = 2'd2;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port plus the IF/ID pipeline register outputs of the fetch stage.
interface fetch_stage_if;

    logic                     imem_en;
    logic [cpu_pkg::XLEN-1:0] imem_addr;
    logic [cpu_pkg::XLEN-1:0] imem_rdata;
    logic                     ifid_valid;
    logic [cpu_pkg::XLEN-1:0] ifid_inst;
    logic [cpu_pkg::XLEN-1:0] ifid_pc;
    logic [cpu_pkg::XLEN-1:0] ifid_pc4;

    modport master (
        output imem_en, imem_addr, ifid_valid, ifid_inst, ifid_pc, ifid_pc4,
        input  imem_rdata
    );

    modport slave (
        input  imem_en, imem_addr, ifid_valid, ifid_inst, ifid_pc, ifid_pc4,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for the word that returns from memory while the pipe is stalled.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_capture,
    input  logic            i_release,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_release) begin
            r_inst <= NOP_INST;
            r_pc   <= '0;
        end else if (i_capture) begin
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end
    end

    assign o_inst = r_inst;
    assign o_pc   = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, 1-cycle synchronous imem interface and IF/ID register,
// with stall absorption through fetch_skid and EX-resolved redirects.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    fetch_stage_if.master   bus
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    fetch_state_t    r_state;

    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_inst;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_pc4;

    logic            w_normal;
    logic            w_capture;
    logic            w_release;
    logic [XLEN-1:0] w_buf_inst;
    logic [XLEN-1:0] w_buf_pc;

    assign w_normal  = ~rst & ~redirect & ~stall;
    assign w_capture = ~rst & ~redirect & stall & (r_state == F_STREAM);
    assign w_release = w_normal & (r_state == F_HELD);

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_capture),
        .i_release (w_release),
        .i_clear   (redirect),
        .i_inst    (bus.imem_rdata),
        .i_pc      (r_inflight_pc),
        .o_inst    (w_buf_inst),
        .o_pc      (w_buf_pc)
    );

    // Issue is suppressed whenever the pipe cannot accept, so at most one word is ever held.
    assign bus.imem_en   = w_normal;
    assign bus.imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_state       <= F_IDLE;
            r_ifid_valid  <= 1'b0;
            r_ifid_inst   <= NOP_INST;
            r_ifid_pc     <= '0;
            r_ifid_pc4    <= '0;
        end else if (redirect) begin
            r_pc         <= align_pc(redirect_target);
            r_state      <= F_IDLE;
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
        end else if (stall) begin
            if (r_state == F_STREAM) begin
                r_state <= F_HELD;
            end
        end else begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_state       <= F_STREAM;
            case (r_state)
                F_STREAM: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_inst  <= bus.imem_rdata;
                    r_ifid_pc    <= r_inflight_pc;
                    r_ifid_pc4   <= r_inflight_pc + 32'd4;
                end
                F_HELD: begin
                    r_ifid_valid <= 1'b1;
                    r_ifid_inst  <= w_buf_inst;
                    r_ifid_pc    <= w_buf_pc;
                    r_ifid_pc4   <= w_buf_pc + 32'd4;
                end
                default: begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_inst  <= NOP_INST;
                    r_ifid_pc    <= '0;
                    r_ifid_pc4   <= '0;
                end
            endcase
        end
    end

    assign bus.ifid_valid = r_ifid_valid;
    assign bus.ifid_inst  = r_ifid_inst;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_pc4   = r_ifid_pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage against a 1-cycle synchronous instruction memory
// whose word at address A is 32'h1000_0000 | A.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    fetch_stage_if u_if ();

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u_if.imem_en) u_if.imem_rdata <= 32'h1000_0000 | u_if.imem_addr;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs, check imem outputs in that cycle and IF/ID after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic d,
                        input logic [31:0] t, input logic e_en, input logic [31:0] e_addr,
                        input logic e_valid, input logic [31:0] e_pc);
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        rst = r; stall = s; redirect = d; redirect_target = t;
        #1;
        chk({tag, " imem_en"}, {31'd0, u_if.imem_en}, {31'd0, e_en});
        chk({tag, " imem_addr"}, u_if.imem_addr, e_addr);
        @(posedge clk);
        #1;
        e_inst = e_valid ? (32'h1000_0000 | e_pc) : 32'h0000_0013;
        e_pc4  = e_valid ? (e_pc + 32'd4) : 32'd0;
        chk({tag, " ifid_valid"}, {31'd0, u_if.ifid_valid}, {31'd0, e_valid});
        chk({tag, " ifid_pc"}, u_if.ifid_pc, e_valid ? e_pc : 32'd0);
        chk({tag, " ifid_inst"}, u_if.ifid_inst, e_inst);
        chk({tag, " ifid_pc4"}, u_if.ifid_pc4, e_pc4);
    endtask

    initial begin
        //             rst   stall redir tgt            en    addr           valid pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'hC};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h14,        1'b1, 32'hC};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h14,        1'b1, 32'hC};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h14,        1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h18,        1'b1, 32'h14};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h100,       1'b0, 32'h1C,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b1, 32'h104};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10C,       1'b1, 32'h104};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h200,       1'b0, 32'h10C,       1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h204,       1'b1, 32'h200};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h208,       1'b0, 32'h0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h0};
        vecs[24] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b0, 32'h0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0};
        vecs[27] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h8,         1'b0, 32'h0};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        u_if.imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("v%0d", i), vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].tgt,
                 vecs[i].en, vecs[i].addr, vecs[i].valid, vecs[i].pc);
        end

        // Single-cycle stall right after restart: held word released with no duplicate.
        step("s1_run",   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0);
        step("s1_stall", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h0);
        step("s1_rel",   1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h4);
        step("s1_next",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 1'b1, 32'h8);

        // Stall held from idle after a redirect: nothing in flight, so no word appears.
        step("s2_redir", 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h10, 1'b0, 32'h0);
        step("s2_stall", 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h40, 1'b0, 32'h0);
        step("s2_go",    1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0);
        step("s2_first", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
